// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

  localparam int FQ_ENTRY_W = 64;

  // Log channel id used by trace messages of this block.
  localparam int FETCH_QUEUE = 7;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrapping pointer counter: clears on reset or clear, otherwise steps by one on inc.
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular {pc, inst} buffer between fetch and decode with flush on redirect.
// Optional zero-latency empty-queue bypass under macro FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             _clk,
  input  logic             _reset,
  input  logic             _flush,
  input  logic             _in_valid,
  input  logic [31:0]      _in_pc,
  input  logic [31:0]      _in_inst,
  output logic             in_ready_,
  output logic             out_valid_,
  output logic [31:0]      out_pc_,
  output logic [31:0]      out_inst_,
  input  logic             _out_ready,
  output logic [PTR_W:0]   count_,
  input  logic             _en_trace
);

  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  fq_entry_t            mem [DEPTH];
  logic [PTR_W-1:0]     wp;
  logic [PTR_W-1:0]     rp;
  logic [PTR_W:0]       cnt;
  logic                 empty;
  logic                 enq;
  logic                 deq;
  logic [FQ_ENTRY_W-1:0] wr_dat;
  fq_entry_t            head;
  logic                 unused_trace;

  // Tracing has no hardware effect; the input is kept for interface compatibility.
  assign unused_trace = _en_trace ^ (FETCH_QUEUE == 0);

  assign empty     = (cnt == '0);
  assign in_ready_ = (cnt != FULL);
  assign wr_dat    = {_in_pc, _in_inst};
  assign head      = mem[rp];
  assign count_    = cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  logic byp_take;

  assign byp      = empty && _in_valid && !_flush;
  assign byp_take = byp && _out_ready;
  assign enq      = _in_valid && in_ready_ && !_flush && !byp_take;
  assign deq      = !empty && _out_ready && !_flush;

  always_comb begin
    out_valid_ = !empty || byp;
    out_pc_    = '0;
    out_inst_  = '0;
    if (!empty) begin
      out_pc_   = head.pc;
      out_inst_ = head.inst;
    end else if (byp) begin
      out_pc_   = _in_pc;
      out_inst_ = _in_inst;
    end
  end
`else
  assign enq = _in_valid && in_ready_ && !_flush;
  assign deq = !empty && _out_ready && !_flush;

  always_comb begin
    out_valid_ = !empty;
    out_pc_    = '0;
    out_inst_  = '0;
    if (!empty) begin
      out_pc_   = head.pc;
      out_inst_ = head.inst;
    end
  end
`endif

  // Slot contents survive reset and flush; only pointers and count are cleared.
  always_ff @(posedge _clk) begin
    if (enq) begin
      mem[wp] <= fq_entry_t'(wr_dat);
    end
  end

  always_ff @(posedge _clk) begin
    if (_reset || _flush) begin
      cnt <= '0;
    end else if (enq && !deq) begin
      cnt <= cnt + (PTR_W+1)'(1);
    end else if (deq && !enq) begin
      cnt <= cnt - (PTR_W+1)'(1);
    end
  end

  fq_ptr #(.W(PTR_W)) u_wp (
    .clk   (_clk),
    .reset (_reset),
    .clear (_flush),
    .inc   (enq),
    .ptr   (wp)
  );

  fq_ptr #(.W(PTR_W)) u_rp (
    .clk   (_clk),
    .reset (_reset),
    .clear (_flush),
    .inc   (deq),
    .ptr   (rp)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [2:0]  count;
  logic        en_trace;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4)) dut (
    ._clk       (clk),
    ._reset     (reset),
    ._flush     (flush),
    ._in_valid  (in_valid),
    ._in_pc     (in_pc),
    ._in_inst   (in_inst),
    .in_ready_  (in_ready),
    .out_valid_ (out_valid),
    .out_pc_    (out_pc),
    .out_inst_  (out_inst),
    ._out_ready (out_ready),
    .count_     (count),
    ._en_trace  (en_trace)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; en_trace = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_count", 32'(count), 32'd0);

    // Three enqueues with decode stalled
    drive(1'b1, 32'h0, 32'h00000013, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("empty_bypass_valid", 32'(out_valid), 32'd1);
`else
    chk("empty_no_bypass_valid", 32'(out_valid), 32'd0);
`endif
    tick();
    chk("lat1_out_valid", 32'(out_valid), 32'd1);
    chk("lat1_out_pc", out_pc, 32'h0);
    drive(1'b1, 32'h4, 32'h00100093, 1'b0); tick();
    drive(1'b1, 32'h8, 32'h00200113, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("three_count", 32'(count), 32'd3);
    chk("three_out_pc", out_pc, 32'h0);
    chk("three_out_inst", out_inst, 32'h00000013);
    chk("three_in_ready", 32'(in_ready), 32'd1);

    // Fill, ignored fifth, then one dequeue reopens the queue
    drive(1'b1, 32'hC, 32'h00300193, 1'b0); tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h10, 32'h00400213, 1'b0); tick();
    chk("fifth_ignored_count", 32'(count), 32'd4);
    chk("fifth_ignored_pc", out_pc, 32'h0);
    drive(1'b1, 32'h10, 32'h00400213, 1'b1);
    chk("full_deq_in_ready_same", 32'(in_ready), 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("after_deq_in_ready", 32'(in_ready), 32'd1);
    chk("after_deq_count", 32'(count), 32'd3);
    chk("after_deq_pc", out_pc, 32'h4);

    // Drain remaining entries in order
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    chk("drain_pc0", out_pc, 32'h4); tick();
    chk("drain_pc1", out_pc, 32'h8); tick();
    chk("drain_pc2", out_pc, 32'hC);
    chk("drain_inst2", out_inst, 32'h00300193); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_pc", out_pc, 32'h0);

    // Streaming: ten pcs through a one-deep steady state across pointer wraps
    drive(1'b1, 32'h100, 32'h10000000, 1'b0); tick();
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h10000000 | 32'(i), 1'b1);
      chk("stream_pc", out_pc, 32'h100 + 32'(4 * (i - 1)));
      chk("stream_inst", out_inst, 32'h10000000 | 32'(i - 1));
      chk("stream_count", 32'(count), 32'd1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    chk("stream_last_pc", out_pc, 32'h124);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("stream_end_count", 32'(count), 32'd0);

    // Flush with three entries and a concurrent enqueue of 0x200
    drive(1'b1, 32'h300, 32'hA0, 1'b0); tick();
    drive(1'b1, 32'h304, 32'hA1, 1'b0); tick();
    drive(1'b1, 32'h308, 32'hA2, 1'b0); tick();
    flush = 1'b1;
    drive(1'b1, 32'h200, 32'hBB, 1'b1);
    chk("flush_cycle_valid_unmasked", 32'(out_valid), 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_pc", out_pc, 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h500, 32'hC0, 1'b0); tick();
    drive(1'b1, 32'h504, 32'hC1, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("post_flush_pc", out_pc, 32'h500);
    chk("post_flush_count", 32'(count), 32'd2);

    // Reset mid-operation with concurrent enqueue/dequeue
    reset = 1'b1;
    drive(1'b1, 32'h508, 32'hC2, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pc", out_pc, 32'h0);
    chk("mid_rst_inst", out_inst, 32'h0);
    chk("mid_rst_count", 32'(count), 32'd0);

    // Empty queue, fetch and decode both ready
    drive(1'b1, 32'h40, 32'h00500293, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid", 32'(out_valid), 32'd1);
    chk("byp_pc", out_pc, 32'h40);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nobyp_valid_same", 32'(out_valid), 32'd0);
    chk("nobyp_pc_same", out_pc, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    chk("nobyp_valid_next", 32'(out_valid), 32'd1);
    chk("nobyp_pc_next", out_pc, 32'h40);
    chk("nobyp_count_next", 32'(count), 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("nobyp_drained", 32'(count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and decode. It captures each fetched {pc, inst} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. It gives fetch a back-pressure signal, and a flush that discards all wrong-path instructions on a redirect. Fetch holds its pc while `in_ready_` is low.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`, read/write pointer width (derived; do not override).

Ports:
- `_clk`  in  1  single clock, all state updates on posedge.
- `_reset`  in  1  synchronous, active-high reset.
- `_flush`  in  1  discard all entries at next edge (branch/exception redirect).
- `_in_valid`  in  1  fetch presents an instruction this cycle.
- `_in_pc`  in  32  pc of the presented instruction.
- `_in_inst`  in  32  instruction word.
- `in_ready_`  out  1  queue accepts an entry this cycle.
- `out_valid_`  out  1  head entry valid for decode.
- `out_pc_`  out  32  head pc.
- `out_inst_`  out  32  head instruction.
- `_out_ready`  in  1  decode consumes head this cycle.
- `count_`  out  PTR_W+1  current occupancy, 0..DEPTH.
- `_en_trace`  in  1  enables `LOG(FETCH_QUEUE, ...)` messages on enqueue, dequeue and flush.

## Operation
- Storage: DEPTH × 64-bit slots {pc, inst}. Write pointer `wp`, read pointer `rp` (PTR_W bits, wrap modulo DEPTH), occupancy `cnt`.
- `in_ready_ = (cnt != DEPTH)`. It depends only on registered state, never on `_out_ready`. A full queue stalls fetch for one cycle even when decode dequeues in that cycle.
- Enqueue: `_in_valid && in_ready_ && !_flush`. The slot at `wp` is written and `wp` increments.
- Dequeue: `out_valid_ && _out_ready && !_flush`. `rp` increments.
- Simultaneous enqueue and dequeue: `cnt` unchanged, both pointers advance.
- `out_valid_ = (cnt != 0)`. When `cnt == 0`, `out_pc_` and `out_inst_` are driven to 0. Otherwise they show the slot at `rp`.
- Flush:
  - At the next edge, `wp`, `rp` and `cnt` are cleared to 0.
  - The incoming entry in the flush cycle is dropped, as is any dequeue in that cycle.
  - Decode must treat `out_valid_` in the flush cycle as already squashed. The queue does not mask it.
- Priority: `_reset` > `_flush` > enqueue/dequeue.
- Slot contents are not cleared by reset or flush. Only the pointers and counter are cleared.

## Timing
- Reset values: `in_ready_` = 1, `out_valid_` = 0, `out_pc_` = 0, `out_inst_` = 0, `count_` = 0. Reset mid-operation discards all entries exactly as flush does.
- Minimum latency without bypass: an entry enqueued at edge N is visible on `out_*` after edge N, i.e. usable by decode in cycle N+1.
- Full queue: `in_ready_` drops in the cycle after the DEPTH-th enqueue. It rises in the cycle after the first dequeue.
- Wrap-around: pointer DEPTH-1 increments to 0. Order is preserved across the wrap.
- Throughput: one enqueue and one dequeue per cycle in steady state.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `cnt == 0`, `_in_valid` = 1 and `_flush` = 0, then `out_valid_` = 1 and `out_pc_`/`out_inst_` = `_in_pc`/`_in_inst` combinationally (0-cycle latency).
  - If `_out_ready` is also high, the entry is consumed directly: no write, pointers and `cnt` unchanged.
  - If `_out_ready` is low, the entry is enqueued normally.
- Macro undefined: no combinational path from `_in_*` to `out_*`. Minimum latency is 1 cycle.

## Structure
- Shared package holds:
  - `FQ_ENTRY_W = 64`;
  - the entry typedef {pc[31:0], inst[31:0]};
  - the `FETCH_QUEUE` log-channel constant.
- One sub-module: `fq_ptr`, a wrapping pointer counter with increment and clear inputs, instantiated for `rp` and `wp`.
- `cnt` and the handshake logic live in the top module.

## Test plan
- Reset, then enqueue pc 0x0/0x4/0x8 with inst 0x00000013/0x00100093/0x00200113 while `_out_ready` = 0 → `count_` = 3, `out_pc_` = 0x0, `out_inst_` = 0x00000013.
- DEPTH = 4: four enqueues with decode stalled → `in_ready_` = 0, `count_` = 4. A fifth `_in_valid` is ignored. One dequeue → `in_ready_` = 1 on the next cycle.
- Continuous enqueue/dequeue of 10 sequential pcs 0x100..0x124 → outputs arrive in order across two pointer wraps, and `count_` stays constant.
- With 3 entries, assert `_flush` together with `_in_valid` (pc 0x200) → next cycle `count_` = 0, `out_valid_` = 0. Pc 0x200 never appears at the output.
- `_reset` asserted with 2 entries and concurrent enqueue/dequeue → all outputs at their reset values on the next cycle.
- With `FETCH_QUEUE_BYPASS_EN`, empty queue, `_in_valid` = 1 (pc 0x40), `_out_ready` = 1 → `out_valid_` = 1 and `out_pc_` = 0x40 in the same cycle, and `count_` stays 0. Without the macro, the same stimulus gives `out_valid_` = 1 one cycle later.
